// File: rtl/wave_analyzer_pkg.sv
// Shared definitions for the waveform analyser: sample format, comparator defaults,
// result field widths and the measurement FSM encoding.
package wave_analyzer_pkg;

    localparam int SAMPLE_W     = 12;
    localparam int FREQ_W       = 20;
    localparam int DUTY_W       = 7;
    localparam int DIV_W        = 34;
    localparam int MID_DEFAULT  = 2048;
    localparam int HYST_DEFAULT = 64;

    localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 12'd4095;
    localparam logic [DUTY_W-1:0]   DUTY_MAX   = 7'd100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DIVIDE  = 2'd2
    } state_t;

    // Crossing counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [FREQ_W-1:0] sat_inc_freq(input logic [FREQ_W-1:0] value,
                                                       input logic            inc);
        if (inc && (value != {FREQ_W{1'b1}})) begin
            return value + 20'd1;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/wave_analyzer_if.sv
// Sample stream in, measurement result out with a valid/ready handshake.
interface wave_analyzer_if;
    import wave_analyzer_pkg::*;

    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                result_valid;
    logic                result_ready;
    logic [FREQ_W-1:0]   freq_count;
    logic [SAMPLE_W-1:0] min_level;
    logic [SAMPLE_W-1:0] max_level;
    logic [DUTY_W-1:0]   duty_pct;
    logic                overrun;

    modport master (
        output sample_in, sample_valid, result_ready,
        input  result_valid, freq_count, min_level, max_level, duty_pct, overrun
    );

    modport slave (
        input  sample_in, sample_valid, result_ready,
        output result_valid, freq_count, min_level, max_level, duty_pct, overrun
    );

endinterface

// File: rtl/wave_analyzer_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses for one
// cycle after the final bit, abort drops any division in flight.
module seq_divider
    import wave_analyzer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] rem_r;
    logic [DIV_W-1:0] quo_r;
    logic [DIV_W-1:0] dsr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;

    logic [DIV_W:0]   shift_s;
    logic             fits_s;
    logic [DIV_W-1:0] rem_s;

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    always_comb begin
        shift_s = {rem_r, quo_r[DIV_W-1]};
        fits_s  = (shift_s >= {1'b0, dsr_r});
        if (fits_s) begin
            rem_s = shift_s[DIV_W-1:0] - dsr_r;
        end else begin
            rem_s = shift_s[DIV_W-1:0];
        end
    end

    // Division sequencing.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            rem_r  <= '0;
            quo_r  <= '0;
            dsr_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start && !busy_r) begin
            rem_r  <= '0;
            quo_r  <= dividend;
            dsr_r  <= divisor;
            cnt_r  <= CNT_W'(DIV_W);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            rem_r <= rem_s;
            quo_r <= {quo_r[DIV_W-2:0], fits_s};
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                busy_r <= 1'b1;
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = quo_r;

endmodule

// File: rtl/wave_analyzer.sv
// Gated-window waveform analyser: rising crossings, min/max level and duty cycle
// of a 12-bit sample stream, presented through a held valid/ready result register.
module wave_analyzer
    import wave_analyzer_pkg::*;
#(
    parameter int GATE_CYCLES = 100000000,
    parameter int MID         = MID_DEFAULT,
    parameter int HYST        = HYST_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    wave_analyzer_if.slave bus
);

    localparam int WIN_W = $clog2(GATE_CYCLES);
    localparam int CNT_W = $clog2(GATE_CYCLES + 1);

    localparam logic [SAMPLE_W:0]  HI_TH   = (SAMPLE_W + 1)'(MID + HYST);
    localparam logic [SAMPLE_W:0]  LO_TH   = (SAMPLE_W + 1)'(MID - HYST);
    localparam logic [WIN_W-1:0]   WIN_END = WIN_W'(GATE_CYCLES - 1);

    state_t              state_r;
    state_t              state_s;

    logic [WIN_W-1:0]    win_cnt_r;
    logic                cmp_r;
    logic [FREQ_W-1:0]   freq_acc_r;
    logic [CNT_W-1:0]    high_acc_r;
    logic [CNT_W-1:0]    valid_acc_r;
    logic [SAMPLE_W-1:0] min_acc_r;
    logic [SAMPLE_W-1:0] max_acc_r;

    logic [FREQ_W-1:0]   snap_freq_r;
    logic [CNT_W-1:0]    snap_high_r;
    logic [CNT_W-1:0]    snap_valid_r;
    logic [SAMPLE_W-1:0] snap_min_r;
    logic [SAMPLE_W-1:0] snap_max_r;

    logic [FREQ_W-1:0]   res_freq_r;
    logic [SAMPLE_W-1:0] res_min_r;
    logic [SAMPLE_W-1:0] res_max_r;
    logic [DUTY_W-1:0]   res_duty_r;
    logic                res_valid_r;
    logic                overrun_r;

    logic                run_s;
    logic                smp_s;
    logic                last_s;
    logic                cmp_s;
    logic                rise_s;
    logic [FREQ_W-1:0]   freq_s;
    logic [CNT_W-1:0]    high_s;
    logic [CNT_W-1:0]    valid_s;
    logic [SAMPLE_W-1:0] min_s;
    logic [SAMPLE_W-1:0] max_s;

    logic                div_start_s;
    logic                div_busy_s;
    logic                div_done_s;
    logic [DIV_W-1:0]    div_quo_s;
    logic [DIV_W-1:0]    dividend_s;
    logic [DIV_W-1:0]    divisor_s;
    logic [DUTY_W-1:0]   duty_s;
    logic                load_s;
    logic                handshake_s;

    // Windows run back to back in MEASURE and DIVIDE; only IDLE or enable=0 stops them.
    assign run_s       = enable && (state_r != ST_IDLE);
    assign smp_s       = run_s && bus.sample_valid;
    assign last_s      = run_s && (win_cnt_r == WIN_END);
    assign handshake_s = res_valid_r && bus.result_ready;

    // Statistics including this cycle's sample, so the closing sample is captured.
    always_comb begin
        if (!smp_s) begin
            cmp_s = cmp_r;
        end else if ({1'b0, bus.sample_in} >= HI_TH) begin
            cmp_s = 1'b1;
        end else if ({1'b0, bus.sample_in} <= LO_TH) begin
            cmp_s = 1'b0;
        end else begin
            cmp_s = cmp_r;
        end
        rise_s  = cmp_s && !cmp_r;
        freq_s  = sat_inc_freq(freq_acc_r, rise_s);
        high_s  = high_acc_r + CNT_W'(smp_s && cmp_s);
        valid_s = valid_acc_r + CNT_W'(smp_s);
        if (smp_s && (bus.sample_in < min_acc_r)) begin
            min_s = bus.sample_in;
        end else begin
            min_s = min_acc_r;
        end
        if (smp_s && (bus.sample_in > max_acc_r)) begin
            max_s = bus.sample_in;
        end else begin
            max_s = max_acc_r;
        end
    end

    // Window counter and accumulators; comparator state survives window boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_r   <= '0;
            cmp_r       <= 1'b0;
            freq_acc_r  <= '0;
            high_acc_r  <= '0;
            valid_acc_r <= '0;
            min_acc_r   <= SAMPLE_MAX;
            max_acc_r   <= '0;
        end else if (!run_s) begin
            win_cnt_r   <= '0;
            freq_acc_r  <= '0;
            high_acc_r  <= '0;
            valid_acc_r <= '0;
            min_acc_r   <= SAMPLE_MAX;
            max_acc_r   <= '0;
        end else if (last_s) begin
            win_cnt_r   <= '0;
            cmp_r       <= cmp_s;
            freq_acc_r  <= '0;
            high_acc_r  <= '0;
            valid_acc_r <= '0;
            min_acc_r   <= SAMPLE_MAX;
            max_acc_r   <= '0;
        end else begin
            win_cnt_r   <= win_cnt_r + {{(WIN_W-1){1'b0}}, 1'b1};
            cmp_r       <= cmp_s;
            freq_acc_r  <= freq_s;
            high_acc_r  <= high_s;
            valid_acc_r <= valid_s;
            min_acc_r   <= min_s;
            max_acc_r   <= max_s;
        end
    end

    // Closed-window snapshot that feeds the divider while the next window runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_freq_r  <= '0;
            snap_high_r  <= '0;
            snap_valid_r <= '0;
            snap_min_r   <= '0;
            snap_max_r   <= '0;
        end else if (last_s) begin
            snap_freq_r  <= freq_s;
            snap_high_r  <= high_s;
            snap_valid_r <= valid_s;
            snap_min_r   <= min_s;
            snap_max_r   <= max_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, divider launch and result load; an empty window never starts the divider.
    always_comb begin
        state_s     = state_r;
        div_start_s = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_MEASURE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                if (!enable) begin
                    state_s = ST_IDLE;
                end else if (last_s) begin
                    state_s = ST_DIVIDE;
                end else begin
                    state_s = ST_MEASURE;
                end
            end
            ST_DIVIDE: begin
                if (!enable) begin
                    state_s = ST_IDLE;
                end else if ((snap_valid_r == '0) || div_done_s) begin
                    load_s  = 1'b1;
                    state_s = ST_MEASURE;
                end else begin
                    div_start_s = !div_busy_s;
                    state_s     = ST_DIVIDE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign dividend_s = {{(DIV_W-CNT_W){1'b0}}, snap_high_r} * 34'd100;
    assign divisor_s  = {{(DIV_W-CNT_W){1'b0}}, snap_valid_r};

    seq_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .abort    (!enable),
        .start    (div_start_s),
        .dividend (dividend_s),
        .divisor  (divisor_s),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_quo_s)
    );

    // Duty percentage; the clamp keeps a corrupted quotient inside the 0-100 range.
    always_comb begin
        if (snap_valid_r == '0) begin
            duty_s = '0;
        end else if (div_quo_s > 34'd100) begin
            duty_s = DUTY_MAX;
        end else begin
            duty_s = div_quo_s[DUTY_W-1:0];
        end
    end

    // Result holding register with overwrite detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_freq_r  <= '0;
            res_min_r   <= '0;
            res_max_r   <= '0;
            res_duty_r  <= '0;
            res_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (load_s) begin
            res_freq_r  <= snap_freq_r;
            res_min_r   <= snap_min_r;
            res_max_r   <= snap_max_r;
            res_duty_r  <= duty_s;
            res_valid_r <= 1'b1;
            overrun_r   <= res_valid_r && !bus.result_ready;
        end else if (handshake_s) begin
            res_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end
    end

    assign bus.result_valid = res_valid_r;
    assign bus.freq_count   = res_freq_r;
    assign bus.min_level    = res_min_r;
    assign bus.max_level    = res_max_r;
    assign bus.duty_pct     = res_duty_r;
    assign bus.overrun      = overrun_r;

endmodule

// File: tb/tb_wave_analyzer.sv
// Bench for wave_analyzer with a 1000-cycle window: table of whole-window patterns
// checked through a result scoreboard, plus handshake, abort and reset sequences.
module tb_wave_analyzer;

    localparam int GATE = 1000;

    localparam int M_SQ50  = 0;
    localparam int M_SQ25  = 1;
    localparam int M_SQ33E = 2;
    localparam int M_EMPTY = 3;
    localparam int M_TRI   = 4;
    localparam int M_NOISY = 5;
    localparam int M_EDGE  = 6;

    typedef struct {
        int row;
        int mode;
        int freq;
        int mn;
        int mx;
        int duty;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;

    wave_analyzer_if bus();

    wave_analyzer #(.GATE_CYCLES(GATE), .MID(2048), .HYST(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    vec_t vecs[7];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Drive window cycle i of a pattern; it is sampled on the following rising edge.
    task automatic drive_cycle(input int mode, input int i);
        int ph;
        logic v;
        logic [11:0] s;
        ph = i % 100;
        v  = 1'b1;
        s  = 12'd0;
        case (mode)
            M_SQ50:  s = (ph < 50) ? 12'd4095 : 12'd0;
            M_SQ25:  s = (ph < 25) ? 12'd4095 : 12'd0;
            M_SQ33E: begin v = ((i % 2) == 0); s = (ph < 33) ? 12'd4095 : 12'd0; end
            M_EMPTY: begin v = 1'b0; s = 12'd3000; end
            M_TRI:   begin ph = i % 200; s = (ph < 100) ? 12'(2000 + ph) : 12'(2200 - ph); end
            M_NOISY: s = ((i % 2) == 1) ? 12'd2120 : 12'd2040;
            M_EDGE:  begin
                v = (i == 0) || (i == GATE - 1);
                s = (i == 0) ? 12'd0 : ((i == GATE - 1) ? 12'd3000 : 12'd4095);
            end
            default: v = 1'b0;
        endcase
        @(posedge clk); #1;
        bus.sample_valid = v;
        bus.sample_in    = s;
    endtask

    task automatic run_range(input int mode, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) drive_cycle(mode, i);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; enable = 1'b0; bus.sample_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Scoreboard: a result accepted on the next edge is popped and compared.
    always @(negedge clk) begin
        vec_t e;
        if (mon_en && bus.result_valid && bus.result_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("row%0d_freq", e.row), bus.freq_count, e.freq);
                chk($sformatf("row%0d_min", e.row), bus.min_level, e.mn);
                chk($sformatf("row%0d_max", e.row), bus.max_level, e.mx);
                chk($sformatf("row%0d_duty", e.row), bus.duty_pct, e.duty);
                chk($sformatf("row%0d_overrun", e.row), bus.overrun, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst = 1'b1; enable = 1'b0;
        bus.sample_in = 12'd0; bus.sample_valid = 1'b0; bus.result_ready = 1'b0;

        vecs[0] = '{0, M_SQ50,  10, 0,    4095, 50};
        vecs[1] = '{1, M_SQ25,  10, 0,    4095, 25};
        vecs[2] = '{2, M_SQ33E, 10, 0,    4095, 34};
        vecs[3] = '{3, M_EMPTY, 0,  4095, 0,    0};
        vecs[4] = '{4, M_TRI,   0,  2000, 2100, 0};
        vecs[5] = '{5, M_NOISY, 1,  2040, 2120, 99};
        vecs[6] = '{6, M_EDGE,  1,  0,    3000, 50};

        do_reset();
        chk("reset_valid", bus.result_valid, 0);
        chk("reset_overrun", bus.overrun, 0);
        chk("reset_freq", bus.freq_count, 0);
        chk("reset_min", bus.min_level, 0);
        chk("reset_max", bus.max_level, 0);
        chk("reset_duty", bus.duty_pct, 0);

        // Back-to-back windows with a consumer that is always ready.
        bus.result_ready = 1'b1;
        mon_en = 1'b1;
        enable = 1'b1;
        foreach (vecs[r]) begin
            exp_q.push_back(vecs[r]);
            run_range(vecs[r].mode, 0, GATE - 1);
        end
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // Consumer stalled across two windows: overwrite, then acknowledge.
        do_reset();
        bus.result_ready = 1'b0;
        enable = 1'b1;
        run_range(M_SQ50, 0, GATE - 1);
        run_range(M_SQ25, 0, 39);
        chk("w1_valid_within_40", bus.result_valid, 1);
        chk("w1_overrun", bus.overrun, 0);
        chk("w1_duty", bus.duty_pct, 50);
        run_range(M_SQ25, 40, GATE - 1);
        run_range(M_SQ25, 0, 39);
        chk("ovr_flag", bus.overrun, 1);
        chk("ovr_valid", bus.result_valid, 1);
        chk("ovr_duty", bus.duty_pct, 25);
        chk("ovr_freq", bus.freq_count, 10);
        bus.result_ready = 1'b1;
        run_range(M_SQ25, 40, 40);
        bus.result_ready = 1'b0;
        chk("ack_valid", bus.result_valid, 0);
        chk("ack_overrun", bus.overrun, 0);

        // Enable dropped mid-window while a result is still unaccepted.
        do_reset();
        bus.result_ready = 1'b0;
        enable = 1'b1;
        run_range(M_SQ50, 0, GATE - 1);
        run_range(M_SQ50, 0, 499);
        enable = 1'b0;
        bad = 0;
        for (int k = 0; k < 1200; k++) begin
            @(posedge clk); #1;
            if (bus.result_valid !== 1'b1 || bus.overrun !== 1'b0 || bus.duty_pct !== 7'd50) bad++;
        end
        chk("idle_keeps_result", bad, 0);
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        chk("idle_ack_valid", bus.result_valid, 0);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (bus.result_valid !== 1'b0) bad++;
        end
        chk("no_result_from_aborted_window", bad, 0);
        enable = 1'b1;
        run_range(M_SQ25, 0, GATE - 1);
        run_range(M_SQ25, 0, 39);
        chk("reenable_duty", bus.duty_pct, 25);
        chk("reenable_freq", bus.freq_count, 10);

        // Reset asserted while the second window's divide is in progress.
        do_reset();
        bus.result_ready = 1'b0;
        enable = 1'b1;
        run_range(M_SQ50, 0, GATE - 1);
        run_range(M_SQ25, 0, GATE - 1);
        run_range(M_SQ25, 0, 9);
        chk("pre_rst_valid", bus.result_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_div_valid", bus.result_valid, 0);
        chk("rst_div_overrun", bus.overrun, 0);
        chk("rst_div_freq", bus.freq_count, 0);
        chk("rst_div_min", bus.min_level, 0);
        chk("rst_div_max", bus.max_level, 0);
        chk("rst_div_duty", bus.duty_pct, 0);
        rst = 1'b0;
        enable = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (bus.result_valid !== 1'b0) bad++;
        end
        chk("no_result_after_rst", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wave_analyzer.md
WAVE_ANALYZER -- requirements
Module: wave_analyzer

Interface
REQ-001 Parameter GATE_CYCLES, default 100000000, measurement window length in clk cycles; 1 s window gives frequency directly in Hz; legal minimum 64.
REQ-002 Parameter MID, default 2048, comparator centre level.
REQ-003 Parameter HYST, default 64, comparator hysteresis half-width.
REQ-004 clk  in  1  system clock; the block has one clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  1 = measurements run; 0 = abort and idle.
REQ-007 sample_in  in  12  unsigned waveform sample, same format as the generator's DAC word.
REQ-008 sample_valid  in  1  sample_in is qualified this cycle.
REQ-009 result_valid  out  1  result fields hold a complete measurement.
REQ-010 result_ready  in  1  consumer accepts the result.
REQ-011 freq_count  out  20  rising crossings per window; saturates at 1048575.
REQ-012 min_level  out  12  smallest valid sample in the window.
REQ-013 max_level  out  12  largest valid sample in the window.
REQ-014 duty_pct  out  7  floor(high_samples*100/valid_samples), range 0-100.
REQ-015 overrun  out  1  an unaccepted result was overwritten.

Function
REQ-016 The FSM SHALL have states IDLE, MEASURE and DIVIDE, with an independent output holding register.
- IDLE -> MEASURE when enable=1.
- MEASURE -> DIVIDE on the last window cycle.
- DIVIDE -> MEASURE when the divider completes.
REQ-017 The window counter SHALL count every clk cycle in MEASURE, regardless of sample_valid.
REQ-018 A window SHALL close on cycle GATE_CYCLES-1, and a sample qualified on that cycle SHALL be included.
REQ-019 The next window SHALL start on the cycle after close; this window runs concurrently with DIVIDE and loses no cycles.
REQ-020 The comparator state SHALL behave as follows:
- sets when a valid sample >= MID+HYST;
- clears when a valid sample <= MID-HYST;
- otherwise holds;
- is retained across windows.
REQ-021 A rising crossing SHALL be a 0->1 comparator transition; each crossing increments the crossing counter, which saturates.
REQ-022 high_samples SHALL count valid samples taken while the comparator state is 1, including the sample that sets it; valid_samples SHALL count all valid samples.
REQ-023 min/max SHALL track valid samples only; a window with no valid samples SHALL report min_level=4095, max_level=0 and duty_pct=0, and SHALL skip the divider.
REQ-024 The duty calculation SHALL use a 34-bit restoring divider, 1 bit per cycle, and SHALL complete within 40 cycles of window close.
REQ-025 When the divider completes, all result fields SHALL load together and result_valid SHALL rise on the next cycle.
REQ-026 The handshake SHALL operate as follows:
- result_valid stays 1 and the fields stay stable until a cycle with result_valid=1 and result_ready=1;
- result_valid drops on the cycle after that handshake unless a new result loads in the same cycle.
REQ-027 If a new result loads while result_valid=1 and result_ready=0, the new result SHALL overwrite the old one and overrun SHALL set; overrun SHALL clear on the next handshake.
REQ-028 If a new result loads on the same cycle as a handshake, the old result SHALL count as accepted, the new result SHALL be presented, and overrun SHALL stay 0.
REQ-029 If enable=0 in any state, the FSM SHALL go to IDLE on the next cycle, discard the partial window and any result in the divider, and keep an already-presented result until it is accepted.

Reset
REQ-030 When rst=1, the following SHALL apply on the next clk edge:
- FSM = IDLE;
- all counters and the comparator state = 0;
- result_valid=0, overrun=0;
- freq_count=0, min_level=0, max_level=0, duty_pct=0.
REQ-031 Reset SHALL take priority over every other input, including asserting mid-window or mid-divide.

Structure
REQ-032 The FSM state encoding, the 12-bit sample width and the default MID/HYST values SHALL be placed in the shared awg package.
REQ-033 The divider SHALL be a separate sub-module, seq_divider: start/busy/done, 34-bit dividend, 34-bit divisor.

Verification
REQ-034 With GATE_CYCLES=1000, the bench SHALL cover these scenarios:
- Square wave, 0/4095, period 100 cycles, valid every cycle -> freq_count=10, min_level=0, max_level=4095, duty_pct=50.
- Same wave, high for 25 of 100 cycles -> duty_pct=25; with sample_valid=0 on every window cycle -> min_level=4095, max_level=0, duty_pct=0.
- Triangle 2000..2100 (within hysteresis) -> freq_count=0.
- Noisy crossing 2040/2120 alternating, each cycle -> at most 1 crossing counted per true edge.
- result_ready held 0 across two windows -> overrun=1 with the second result shown; then result_ready=1 -> result_valid=0 and overrun=0 the next cycle.
- enable dropped at cycle 500 -> no result for that window; rst asserted mid-divide -> all outputs 0 the next cycle.
